// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment codes, BCD conversion and counter-width helpers
package seg7_pkg;
   localparam logic [0:6] SEG_0     = 7'b0000001;
   localparam logic [0:6] SEG_1     = 7'b1001111;
   localparam logic [0:6] SEG_2     = 7'b0010010;
   localparam logic [0:6] SEG_3     = 7'b0000110;
   localparam logic [0:6] SEG_4     = 7'b1001100;
   localparam logic [0:6] SEG_5     = 7'b0100100;
   localparam logic [0:6] SEG_6     = 7'b0100000;
   localparam logic [0:6] SEG_7     = 7'b0001111;
   localparam logic [0:6] SEG_8     = 7'b0000000;
   localparam logic [0:6] SEG_9     = 7'b0000100;
   localparam logic [0:6] SEG_BLANK = 7'b1111111;
   localparam int DEF_TICK_DIV    = 100_000_000;
   localparam int DEF_REFRESH_DIV = 100_000;
   localparam int DEF_TICK_W      = $clog2(DEF_TICK_DIV);
   localparam int DEF_REFRESH_W   = $clog2(DEF_REFRESH_DIV);
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
   function automatic logic [31:0] dec_to_bcd(input int unsigned value, input int digits);
      logic [31:0] r;
      int unsigned v;
      r = '0;
      v = value;
      for (int i = 0; i < 8; i++)
         if (i < digits) begin
            r[4*i+:4] = 4'(v % 10);
            v = v / 10;
         end
      return r;
   endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to active-low common-anode cathodes with blanking
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] bcd_i,
   input  logic       blank_i,
   output logic [0:6] seg_o
);
   // non-decimal codes and the blank request both turn every segment off
   always_comb begin
      seg_o = SEG_BLANK;
      if (!blank_i)
         case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
         endcase
   end
endmodule

// File: rtl/bcd_updown_counter_7seg.sv
// bcd_updown_counter_7seg: BCD up/down counter with multiplexed 7-segment drive
module bcd_updown_counter_7seg
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int MAX_VALUE   = 999,
   parameter int TICK_DIV    = DEF_TICK_DIV,
   parameter int REFRESH_DIV = DEF_REFRESH_DIV
) (
   input  logic                    clk_100Mhz,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    up_down,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   input  logic                    blank_lz,
   output logic [4*NUM_DIGITS-1:0] count_bcd,
   output logic                    wrap,
   output logic [NUM_DIGITS-1:0]   Anode_Activate,
   output logic [0:6]              seg_out
);
   localparam int W  = 4 * NUM_DIGITS;
   localparam int TW = cnt_w(TICK_DIV);
   localparam int RW = cnt_w(REFRESH_DIV);
   localparam int SW = cnt_w(NUM_DIGITS);
   localparam logic [31:0]  MAX_FULL = dec_to_bcd(MAX_VALUE, NUM_DIGITS);
   localparam logic [W-1:0] MAX_BCD  = MAX_FULL[W-1:0];
   logic [W-1:0]  count_q, count_d, load_fix, inc, dec;
   logic [TW-1:0] tick_cnt_q;
   logic [RW-1:0] ref_cnt_q;
   logic [SW-1:0] sel_q;
   logic [3:0]    cur_digit;
   logic          wrap_q, wrap_d, tick, ref_term, step, at_max, at_zero, carry, borrow, upper_nz;
   assign tick     = tick_cnt_q == TW'(TICK_DIV - 1);
   assign ref_term = ref_cnt_q == RW'(REFRESH_DIV - 1);
   assign step     = tick & en & ~load;
   assign at_max   = count_q == MAX_BCD;
   assign at_zero  = count_q == '0;
   // per-digit load sanitising and ripple BCD increment/decrement
   always_comb begin
      carry  = 1'b1;
      borrow = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         load_fix[4*i+:4] = (load_value[4*i+:4] > 4'd9) ? 4'd0 : load_value[4*i+:4];
         inc[4*i+:4] = carry ? ((count_q[4*i+:4] == 4'd9) ? 4'd0 : count_q[4*i+:4] + 4'd1) : count_q[4*i+:4];
         dec[4*i+:4] = borrow ? ((count_q[4*i+:4] == 4'd0) ? 4'd9 : count_q[4*i+:4] - 4'd1) : count_q[4*i+:4];
         carry  = carry & (count_q[4*i+:4] == 4'd9);
         borrow = borrow & (count_q[4*i+:4] == 4'd0);
      end
   end
   // load beats tick; the modulus check replaces the ripple result at either end
   always_comb begin
      count_d = load ? ((load_fix > MAX_BCD) ? '0 : load_fix) :
                ~step ? count_q :
                up_down ? (at_max ? '0 : inc) : (at_zero ? MAX_BCD : dec);
      wrap_d  = step & (up_down ? at_max : at_zero);
   end
   // count, tick divider and digit-scan state
   always_ff @(posedge clk_100Mhz or posedge reset)
      if (reset) begin
         count_q    <= '0;
         wrap_q     <= 1'b0;
         tick_cnt_q <= '0;
         ref_cnt_q  <= '0;
         sel_q      <= '0;
      end else begin
         count_q    <= count_d;
         wrap_q     <= wrap_d;
         tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
         ref_cnt_q  <= ref_term ? '0 : ref_cnt_q + 1'b1;
         if (ref_term)
            sel_q <= (sel_q == SW'(NUM_DIGITS - 1)) ? '0 : sel_q + 1'b1;
      end
   // pick the scanned digit and see whether it and everything above it is zero
   always_comb begin
      cur_digit = '0;
      upper_nz  = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (SW'(i) == sel_q)
            cur_digit = count_q[4*i+:4];
         if (SW'(i) >= sel_q && count_q[4*i+:4] != 4'd0)
            upper_nz = 1'b1;
      end
   end
   assign Anode_Activate = ~(NUM_DIGITS'(1) << sel_q);
   assign count_bcd      = count_q;
   assign wrap           = wrap_q;
   seg7_decode u_dec (
      .bcd_i  (cur_digit),
      .blank_i(blank_lz & (sel_q != '0) & ~upper_nz),
      .seg_o  (seg_out)
   );
endmodule

// File: tb/tb_bcd_updown_counter_7seg.sv
// tb_bcd_updown_counter_7seg: directed plus random checks of two counter configurations
module tb_bcd_updown_counter_7seg;
   localparam int TD = 4;
   localparam int RD = 2;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic en [2];
   logic ud [2];
   logic ld [2];
   logic blz [2];
   logic [31:0] lv [2];
   logic [11:0] cnt_a;
   logic [15:0] cnt_b;
   logic wrap_a, wrap_b;
   logic [2:0] an_a;
   logic [3:0] an_b;
   logic [0:6] seg_a, seg_b;
   int checks = 0;
   int errors = 0;
   int nd [2] = '{3, 4};
   int mx [2] = '{12, 9999};
   int m_cnt [2], m_tick [2], m_ref [2], m_sel [2];
   bit m_wrap [2];
   logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

   always #5 clk = ~clk;

   bcd_updown_counter_7seg #(.NUM_DIGITS(3), .MAX_VALUE(12), .TICK_DIV(TD), .REFRESH_DIV(RD)) u_a (
      .clk_100Mhz(clk), .reset(reset), .en(en[0]), .up_down(ud[0]), .load(ld[0]),
      .load_value(lv[0][11:0]), .blank_lz(blz[0]), .count_bcd(cnt_a), .wrap(wrap_a),
      .Anode_Activate(an_a), .seg_out(seg_a));

   bcd_updown_counter_7seg #(.NUM_DIGITS(4), .MAX_VALUE(9999), .TICK_DIV(TD), .REFRESH_DIV(RD)) u_b (
      .clk_100Mhz(clk), .reset(reset), .en(en[1]), .up_down(ud[1]), .load(ld[1]),
      .load_value(lv[1][15:0]), .blank_lz(blz[1]), .count_bcd(cnt_b), .wrap(wrap_b),
      .Anode_Activate(an_b), .seg_out(seg_b));

   function automatic int pow10(input int n);
      int p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   function automatic logic [31:0] to_bcd(input int v, input int n);
      logic [31:0] r = '0;
      for (int i = 0; i < n; i++) begin
         r[4*i+:4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic int from_load(input logic [31:0] l, input int n);
      int v = 0;
      int d;
      for (int i = 0; i < n; i++) begin
         d = int'(l[4*i+:4]);
         if (d > 9) d = 0;
         v = v + d * pow10(i);
      end
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mreset(input int k);
      m_cnt[k] = 0; m_tick[k] = 0; m_ref[k] = 0; m_sel[k] = 0; m_wrap[k] = 0;
   endtask

   task automatic upd(input int k);
      bit t;
      int v;
      if (reset) begin
         mreset(k);
         return;
      end
      t = m_tick[k] == TD - 1;
      m_tick[k] = t ? 0 : m_tick[k] + 1;
      m_wrap[k] = 0;
      if (ld[k]) begin
         v = from_load(lv[k], nd[k]);
         m_cnt[k] = (v > mx[k]) ? 0 : v;
      end else if (t && en[k]) begin
         if (ud[k]) begin
            if (m_cnt[k] == mx[k]) begin m_cnt[k] = 0; m_wrap[k] = 1; end
            else m_cnt[k]++;
         end else begin
            if (m_cnt[k] == 0) begin m_cnt[k] = mx[k]; m_wrap[k] = 1; end
            else m_cnt[k]--;
         end
      end
      if (m_ref[k] == RD - 1) begin
         m_ref[k] = 0;
         m_sel[k] = (m_sel[k] == nd[k] - 1) ? 0 : m_sel[k] + 1;
      end else m_ref[k]++;
   endtask

   task automatic check_dut(input int k);
      int s;
      bit blank;
      logic [31:0] e_seg;
      s = m_sel[k];
      blank = blz[k] && s > 0 && m_cnt[k] < pow10(s);
      e_seg = blank ? 32'h7F : 32'(seg_tab[(m_cnt[k] / pow10(s)) % 10]);
      chk($sformatf("count%0d", k), k ? 32'(cnt_b) : 32'(cnt_a), to_bcd(m_cnt[k], nd[k]));
      chk($sformatf("wrap%0d", k), k ? 32'(wrap_b) : 32'(wrap_a), 32'(m_wrap[k]));
      chk($sformatf("anode%0d", k), k ? 32'(an_b) : 32'(an_a), ~(32'd1 << s) & ((32'd1 << nd[k]) - 1));
      chk($sformatf("seg%0d", k), k ? 32'(seg_b) : 32'(seg_a), e_seg);
   endtask

   task automatic cyc();
      @(posedge clk);
      upd(0);
      upd(1);
      @(negedge clk);
      check_dut(0);
      check_dut(1);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         en[k] = 0; ud[k] = 1; ld[k] = 0; blz[k] = 0; lv[k] = '0;
         mreset(k);
      end
      reset = 1;
      repeat (3) cyc();
      chk("rst_anode", 32'(an_a), 32'b110);
      chk("rst_seg", 32'(seg_a), 32'b0000001);
      // count up through the modulus and wrap
      reset = 0; en[0] = 1; ud[0] = 1;
      repeat (4 * 14) cyc();
      // count down from zero after reset
      reset = 1; cyc(); reset = 0; ud[0] = 0;
      repeat (4) cyc();
      chk("down_first", 32'(cnt_a), 32'h012);
      chk("down_wrap", 32'(wrap_a), 32'd1);
      repeat (4) cyc();
      chk("down_second", 32'(cnt_a), 32'h011);
      // loads: coinciding with a tick, invalid digit, above modulus
      ud[0] = 1;
      for (int n = 0; n < TD && m_tick[0] != TD - 1; n++) cyc();
      ld[0] = 1; lv[0] = 32'h009; cyc();
      chk("load_tick", 32'(cnt_a), 32'h009);
      lv[0] = 32'h0A5; cyc();
      chk("load_bad_digit", 32'(cnt_a), 32'h005);
      lv[0] = 32'h013; cyc();
      chk("load_over_max", 32'(cnt_a), 32'h000);
      // display scan with and without leading-zero blanking
      en[0] = 0; lv[0] = 32'h005; cyc(); ld[0] = 0;
      blz[0] = 1; repeat (8) cyc();
      blz[0] = 0; repeat (6) cyc();
      // four-digit carry and borrow ripple
      ld[1] = 1; lv[1] = 32'h0999; cyc(); ld[1] = 0;
      en[1] = 1; ud[1] = 1;
      for (int n = 0; n < TD && m_tick[1] != TD - 1; n++) cyc();
      cyc();
      chk("carry_ripple", 32'(cnt_b), 32'h1000);
      ld[1] = 1; lv[1] = 32'h1000; ud[1] = 0; cyc(); ld[1] = 0;
      for (int n = 0; n < TD && m_tick[1] != TD - 1; n++) cyc();
      cyc();
      chk("borrow_ripple", 32'(cnt_b), 32'h0999);
      // random traffic on both counters
      repeat (400) begin
         for (int k = 0; k < 2; k++) begin
            en[k] = ($urandom_range(0, 3) != 0);
            ud[k] = 1'($urandom_range(0, 1));
            ld[k] = ($urandom_range(0, 15) == 0);
            blz[k] = 1'($urandom_range(0, 1));
            lv[k] = $urandom_range(0, 1) ? 32'($urandom) : to_bcd(int'($urandom_range(0, mx[k])), nd[k]);
         end
         cyc();
      end
      for (int k = 0; k < 2; k++) ld[k] = 0;
      // asynchronous reset while a wrap pulse is showing
      en[0] = 1; ud[0] = 1; ld[0] = 1; lv[0] = 32'h012; cyc(); ld[0] = 0;
      for (int n = 0; n < 2 * TD && !m_wrap[0]; n++) cyc();
      chk("wrap_pending", 32'(wrap_a), 32'd1);
      #2 reset = 1;
      #1;
      mreset(0); mreset(1);
      check_dut(0);
      check_dut(1);
      chk("async_count", 32'(cnt_a), 32'h000);
      chk("async_anode", 32'(an_a), 32'b110);
      chk("async_seg", 32'(seg_a), 32'b0000001);
      cyc();
      reset = 0;
      repeat (8) cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bcd_updown_counter_7seg.md
Name: bcd_updown_counter_7seg

Overview:
Parametrised multi-digit decimal up/down counter with a time-multiplexed common-anode 7-segment driver for the Basys3 display. It counts in BCD on a divided one-shot tick and wraps at a programmable modulus. It adds parallel load, direction control and leading-zero blanking. It sits between the board clock/reset pins and the anode/cathode pins, replacing the fixed mod-1000 up-counter.

Parameters:
NUM_DIGITS, 4, number of displayed BCD digits (1..8); digit 0 is least significant.
MAX_VALUE, 999, terminal count in decimal; must be < 10**NUM_DIGITS; count range 0..MAX_VALUE.
TICK_DIV, 100_000_000, clk_100Mhz cycles per count tick (>= 2).
REFRESH_DIV, 100_000, clk_100Mhz cycles each digit is lit (>= 2).

Ports:
clk_100Mhz  input  1  system clock, 100 MHz
reset  input  1  asynchronous, active-high reset; acts directly on every flop; upstream owns deassertion synchronisation
en  input  1  count enable, sampled on tick
up_down  input  1  1 = count up, 0 = count down
load  input  1  synchronous parallel load strobe
load_value  input  4*NUM_DIGITS  BCD value to load; digit i in bits [4i+3:4i]
blank_lz  input  1  1 = blank leading zeros
count_bcd  output  4*NUM_DIGITS  current count, registered BCD
wrap  output  1  one-cycle pulse on modulus wrap in either direction
Anode_Activate  output  NUM_DIGITS  active-low one-hot digit enable
seg_out  output  7 [0:6]  active-low cathodes, bit 0 = a ... bit 6 = g

Behaviour:
- Reset values: count_bcd=0, wrap=0, tick counter=0, digit_sel=0, refresh counter=0. Anode_Activate={all 1 except bit0=0}. seg_out=7'b0000001.
- Tick: tick_cnt counts 0..TICK_DIV-1 and then returns to 0. tick is 1 for the single cycle where tick_cnt==TICK_DIV-1. It is free-running and independent of en.
- Priority per clock edge: load > (tick & en) > hold.
- Load: in the cycle after the load edge, count_bcd equals load_value. Any digit >9 loads as 0. If the loaded value is greater than MAX_VALUE, count loads 0. Load does not reset tick_cnt. A tick in the same cycle is ignored. wrap stays 0.
- Count up: if count==MAX_VALUE, next count is 0 and wrap=1 for one cycle. Otherwise BCD increment with ripple carry; a digit at 9 goes to 0 with carry.
- Count down: if count==0, next count is MAX_VALUE and wrap=1 for one cycle. Otherwise BCD decrement with borrow; a digit at 0 goes to 9 with borrow.
- MAX_VALUE is converted to a BCD constant at elaboration. No division or modulo operators are allowed in the datapath.
- up_down change takes effect on the next tick. en low: count holds and wrap=0.
- Display: refresh_cnt counts 0..REFRESH_DIV-1. On its terminal cycle, digit_sel advances, wrapping from NUM_DIGITS-1 to 0. No dead slot, so every anode slot is used.
- Anode_Activate = ~(1 << digit_sel). seg_out is a combinational decode of count_bcd digit[digit_sel]. Latency from a count update to seg_out is 0 cycles once that digit is selected.
- Blanking: if blank_lz=1, digit_sel>0, and all digits from digit_sel up to NUM_DIGITS-1 are 0, then seg_out=7'b1111111. The anode stays driven. Digit 0 is never blanked.
- Segment encoding, 0..9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100. Other values: 1111111.
- Reset mid-operation: all state returns to the reset values immediately (asynchronously), including a wrap pulse in progress.

Decomposition:
- Package seg7_pkg holds:
  - the segment code constants SEG_0..SEG_9 and SEG_BLANK;
  - function dec_to_bcd(value, digits) for MAX_VALUE conversion;
  - localparam widths for the tick and refresh counters, via $clog2.
- Sub-module seg7_decode: a combinational 4-bit BCD plus blank input to 7-bit active-low cathodes. It is shared with future display blocks.
- Counter, tick and refresh logic stay in the top module.

Test Plan:
All scenarios use NUM_DIGITS=3, MAX_VALUE=12, TICK_DIV=4, REFRESH_DIV=2 unless noted.
1. Reset for 3 cycles, then release, en=1, up_down=1 -> count_bcd 000, 001, ..., 012, then 000 with wrap=1 for exactly one cycle. Ticks fall on every 4th cycle.
2. After reset, en=1, up_down=0 -> the first tick gives count_bcd=012 (12'h012) and wrap pulses. The next tick gives 011.
3. load=1 with load_value=12'h009 coinciding with a tick -> count=009 and there is no increment that cycle. Then load 12'h0A5 -> count=005 (invalid digit loads as 0). Then load 12'h013 -> count=000 (above MAX_VALUE).
4. count=005, blank_lz=1 -> anodes cycle 110, 101, 011 every 2 cycles. seg_out is 0100100 on 110 and 1111111 on 101/011. With blank_lz=0 the upper digits show 0000001.
5. Assert reset asynchronously mid-count, between clock edges -> count_bcd=0, wrap=0, Anode_Activate=110 and seg_out=0000001 before the next edge.
6. NUM_DIGITS=4, MAX_VALUE=9999, load 12'h0999 wait 16'h0999, up -> the next tick gives 1000 (3-digit carry ripple). Loading 16'h1000 and counting down gives 0999.
